mii_rx_framer: RTL and testbench
================================

// Module: mii_rx_framer
// PURPOSE
//  MII receive framer, mii0_clk domain: sits directly behind the PHY RX pins and feeds the MIIulatorTop datapath.
//  Strips preamble/SFD, packs nibbles (low nibble first) into bytes, marks SOF/EOF, validates length.
//  Streams bytes with per-frame status; no backpressure, so the sink accepts every beat.
// PARAMETERS
//  MIN_FRAME_BYTES   64    min bytes DA..FCS inclusive; shorter frames get err_short
//  MAX_FRAME_BYTES   1522  max bytes; byte MAX+1 truncates the frame with err_long
//  MIN_PRE_NIBBLES   2     0x5 nibbles required before SFD
//  LEN_W             11    frame_len width; must hold MAX_FRAME_BYTES
// PORTS
//  mii0_clk    in   1      MII RX clock (25 MHz); only clock
//  rst_n       in   1      async assert, active-low reset
//  mii0_en     in   1      RX_DV
//  mii0_er     in   1      RX_ER
//  mii0_d      in   4      RX nibble; mii0_d[0] = byte bit 0 on first nibble
//  out_data    out  8      frame byte
//  out_valid   out  1      out_data valid this cycle
//  out_sof     out  1      first byte (DA[47:40]) of frame
//  out_eof     out  1      last byte of frame; status valid with it
//  frame_len   out  LEN_W  bytes in frame, valid with out_eof
//  err_short   out  1      with eof: len < MIN_FRAME_BYTES
//  err_long    out  1      with eof: truncated at MAX_FRAME_BYTES
//  err_align   out  1      with eof: odd nibble count, trailing nibble dropped
//  err_rx      out  1      with eof: mii0_er seen in DATA
//  crc_err     out  1      with eof: FCS residue bad (0 without macro)
//  frame_cnt   out  16     good frames, saturating
//  err_cnt     out  16     errored or aborted frames, saturating
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, en_q = 1.
//  en_q = registered mii0_en. Rising-edge gating means a frame in flight at reset release is ignored.
//  FSM states: IDLE, PRE, DATA, DROP.
//   IDLE: en & !en_q & d==5 -> PRE, pcnt=1.  en & !en_q & d!=5 -> DROP.
//   PRE:  !en -> IDLE.  d==5 -> pcnt++ (saturate).  d==D & pcnt>=MIN_PRE_NIBBLES -> DATA.  Otherwise -> DROP.
//   DATA: en -> nibble phase toggles; phase 0 loads lo, phase 1 completes byte.  !en -> close frame -> IDLE.
//   DROP: wait !en -> IDLE; nothing is emitted.
//  One-byte hold register: a completed byte is emitted when the next byte completes.
//   out_valid is registered and fires the cycle after the completing nibble edge.
//   The held byte is emitted with out_eof=1 the cycle after en is sampled low.
//   Last byte therefore emits 1 cycle after en falls; out_sof on first emitted byte.
//  Length: byte counter saturates at MAX_FRAME_BYTES+1.
//   On completion of byte MAX+1: emit held byte as eof, err_long=1, -> DROP.
//  Odd phase at en fall: drop the partial nibble, err_align=1.
//  Zero bytes after SFD: no beat emitted, err_cnt++.
//  mii0_er in DATA is sticky until eof and sets err_rx.
//  When en falls and a byte completes simultaneously, en wins; that nibble was never sampled as valid.
//  Counters: frame_cnt++ at eof when no err_* is set; err_cnt++ otherwise and for PRE->DROP.
//  Reset mid-frame: beats stop immediately with no eof; downstream discards any open frame on reset.
// CONFIGURATION
//  MII_RX_CRC_CHECK_EN defined: CRC-32 (poly 04C11DB7, reflected, init FFFFFFFF) runs over every DATA byte incl FCS.
//   crc_err = (residue != 32'hC704DD7B) at eof; crc_err counts as an error for the counters.
//  Undefined: CRC logic absent, crc_err tied 0.
// STRUCTURE
//  Package mii_pkg: FSM state enum, MII_PRE_NIB=4'h5, MII_SFD_NIB=4'hD, CRC32_POLY, CRC32_RESIDUE.
//  Sub-module mii_rx_crc32: byte-wide combinational next-CRC plus register, clear/enable inputs.
//   Instantiated only under MII_RX_CRC_CHECK_EN.
// TESTING
//  1. 14x 0x5, D, then 48 bytes (DA 54ff01212324, SA 123456789abc, type 1234, 30-byte text, FCS)
//     -> 48 beats, sof on 0x54, eof on byte 48, frame_len=48, err_short=1, err_cnt=1.
//  2. Same frame padded to 64 bytes with valid FCS, macro on
//     -> frame_len=64, all err_*=0, crc_err=0, frame_cnt=1. Flip one payload bit -> crc_err=1.
//  3. 65-byte frame plus 1 extra nibble
//     -> eof at byte 65, err_align=1; that trailing nibble is never emitted.
//  4. 1600-byte frame -> eof at byte 1522, err_long=1, no further beats until next frame.
//  5. mii0_er pulsed at byte 20 -> err_rx=1 on eof.
//     Preamble 5,5,D with MIN_PRE_NIBBLES=3 -> DROP, no beats, err_cnt++.
//  6. Assert rst_n low at byte 30, release with en high -> no beats until the next en rising edge;
//     next frame received normally.

Source files
------------

// File: rtl/mii_pkg.sv
// Shared types and constants for the MII receive framer: FSM states, preamble/SFD
// nibbles and the reflected CRC-32 helpers used when MII_RX_CRC_CHECK_EN is defined.
package mii_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_DROP
  } mii_state_t;

  localparam logic [3:0]  MII_PRE_NIB   = 4'h5;
  localparam logic [3:0]  MII_SFD_NIB   = 4'hD;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // LSB-first byte update; the register keeps the reflected form, no final inversion.
  function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    logic [31:0] p;
    c = crc;
    p = bitrev32(CRC32_POLY);
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ p;
      else             c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/mii_rx_crc32.sv
// Byte-wide CRC-32 accumulator (reflected, init all-ones). Used by mii_rx_framer
// only when MII_RX_CRC_CHECK_EN is defined.
module mii_rx_crc32
  import mii_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_crc
);

  logic [31:0] r_crc;
  logic [31:0] w_crc_next;

  assign w_crc_next = crc32_next(r_crc, i_byte);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_crc <= 32'hFFFF_FFFF;
    else if (i_clr) r_crc <= 32'hFFFF_FFFF;
    else if (i_en)  r_crc <= w_crc_next;
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/mii_rx_framer.sv
// MII receive framer: strips preamble/SFD, packs nibbles into bytes, marks SOF/EOF and
// reports per-frame status. Define MII_RX_CRC_CHECK_EN to enable the FCS residue check.
module mii_rx_framer
  import mii_pkg::*;
#(
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1522,
  parameter int MIN_PRE_NIBBLES = 2,
  parameter int LEN_W           = 11
) (
  input  logic             mii0_clk,
  input  logic             rst_n,
  input  logic             mii0_en,
  input  logic             mii0_er,
  input  logic [3:0]       mii0_d,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eof,
  output logic [LEN_W-1:0] frame_len,
  output logic             err_short,
  output logic             err_long,
  output logic             err_align,
  output logic             err_rx,
  output logic             crc_err,
  output logic [15:0]      frame_cnt,
  output logic [15:0]      err_cnt
);

  localparam int                PCNT_W = $clog2(MIN_PRE_NIBBLES + 2);
  localparam logic [PCNT_W-1:0] P_MIN  = PCNT_W'(MIN_PRE_NIBBLES);
  localparam logic [LEN_W-1:0]  L_MIN  = LEN_W'(MIN_FRAME_BYTES);
  localparam logic [LEN_W-1:0]  L_MAX  = LEN_W'(MAX_FRAME_BYTES);

  mii_state_t        r_state, w_state_nxt;
  logic              r_en_q;
  logic [PCNT_W-1:0] r_pcnt, w_pcnt_nxt;
  logic              r_phase, w_phase_nxt;
  logic [3:0]        r_lo, w_lo_nxt;
  logic [7:0]        r_hold, w_hold_nxt;
  logic              r_hold_vld, w_hold_vld_nxt;
  logic              r_sof_pend, w_sof_pend_nxt;
  logic [LEN_W-1:0]  r_byte_cnt, w_byte_cnt_nxt;
  logic              r_rx_err, w_rx_err_nxt;

  logic [7:0]        r_out_data, w_out_data_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic              r_out_sof, w_out_sof_nxt;
  logic              r_out_eof, w_out_eof_nxt;
  logic [LEN_W-1:0]  r_frame_len, w_frame_len_nxt;
  logic              r_err_short, w_err_short_nxt;
  logic              r_err_long, w_err_long_nxt;
  logic              r_err_align, w_err_align_nxt;
  logic              r_err_rx, w_err_rx_nxt;
  logic              r_crc_err, w_crc_err_nxt;
  logic [15:0]       r_frame_cnt, w_frame_cnt_nxt;
  logic [15:0]       r_err_cnt, w_err_cnt_nxt;

  logic              w_rise;
  logic              w_sfd_hit;
  logic [7:0]        w_byte;
  logic              w_crc_bad;
  logic              w_close;
  logic              w_close_err;
  logic              w_abort;

  assign w_rise    = mii0_en & ~r_en_q;
  assign w_sfd_hit = (r_state == ST_PRE) & mii0_en & (mii0_d == MII_SFD_NIB) & (r_pcnt >= P_MIN);
  assign w_byte    = {mii0_d, r_lo};

`ifdef MII_RX_CRC_CHECK_EN
  logic        w_byte_done;
  logic [31:0] w_crc;

  assign w_byte_done = (r_state == ST_DATA) & mii0_en & r_phase;

  mii_rx_crc32 u_crc (
    .clk    (mii0_clk),
    .rst_n  (rst_n),
    .i_clr  (w_sfd_hit),
    .i_en   (w_byte_done),
    .i_byte (w_byte),
    .o_crc  (w_crc)
  );

  assign w_crc_bad = (bitrev32(w_crc) != CRC32_RESIDUE);
`else
  assign w_crc_bad = 1'b0;
`endif

  always_ff @(posedge mii0_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_en_q      <= 1'b1;
      r_pcnt      <= '0;
      r_phase     <= 1'b0;
      r_lo        <= '0;
      r_hold      <= '0;
      r_hold_vld  <= 1'b0;
      r_sof_pend  <= 1'b0;
      r_byte_cnt  <= '0;
      r_rx_err    <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_eof   <= 1'b0;
      r_frame_len <= '0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      r_err_align <= 1'b0;
      r_err_rx    <= 1'b0;
      r_crc_err   <= 1'b0;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_en_q      <= mii0_en;
      r_pcnt      <= w_pcnt_nxt;
      r_phase     <= w_phase_nxt;
      r_lo        <= w_lo_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_vld  <= w_hold_vld_nxt;
      r_sof_pend  <= w_sof_pend_nxt;
      r_byte_cnt  <= w_byte_cnt_nxt;
      r_rx_err    <= w_rx_err_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_sof   <= w_out_sof_nxt;
      r_out_eof   <= w_out_eof_nxt;
      r_frame_len <= w_frame_len_nxt;
      r_err_short <= w_err_short_nxt;
      r_err_long  <= w_err_long_nxt;
      r_err_align <= w_err_align_nxt;
      r_err_rx    <= w_err_rx_nxt;
      r_crc_err   <= w_crc_err_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pcnt_nxt      = r_pcnt;
    w_phase_nxt     = r_phase;
    w_lo_nxt        = r_lo;
    w_hold_nxt      = r_hold;
    w_hold_vld_nxt  = r_hold_vld;
    w_sof_pend_nxt  = r_sof_pend;
    w_byte_cnt_nxt  = r_byte_cnt;
    w_rx_err_nxt    = r_rx_err;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = 1'b0;
    w_out_sof_nxt   = 1'b0;
    w_out_eof_nxt   = 1'b0;
    w_frame_len_nxt = '0;
    w_err_short_nxt = 1'b0;
    w_err_long_nxt  = 1'b0;
    w_err_align_nxt = 1'b0;
    w_err_rx_nxt    = 1'b0;
    w_crc_err_nxt   = 1'b0;
    w_close         = 1'b0;
    w_abort         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          if (mii0_d == MII_PRE_NIB) begin
            w_state_nxt = ST_PRE;
            w_pcnt_nxt  = PCNT_W'(1);
          end else begin
            w_state_nxt = ST_DROP;
          end
        end
      end
      ST_PRE: begin
        if (!mii0_en) begin
          w_state_nxt = ST_IDLE;
        end else if (mii0_d == MII_PRE_NIB) begin
          if (r_pcnt != '1) w_pcnt_nxt = r_pcnt + 1'b1;
        end else if (w_sfd_hit) begin
          w_state_nxt    = ST_DATA;
          w_phase_nxt    = 1'b0;
          w_hold_vld_nxt = 1'b0;
          w_sof_pend_nxt = 1'b1;
          w_byte_cnt_nxt = '0;
          w_rx_err_nxt   = 1'b0;
        end else begin
          w_state_nxt = ST_DROP;
          w_abort     = 1'b1;
        end
      end
      ST_DATA: begin
        if (!mii0_en) begin
          // Any half-received nibble is discarded; the held byte closes the frame.
          w_state_nxt    = ST_IDLE;
          w_phase_nxt    = 1'b0;
          w_hold_vld_nxt = 1'b0;
          if (r_hold_vld) begin
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = r_hold;
            w_out_sof_nxt   = r_sof_pend;
            w_sof_pend_nxt  = 1'b0;
            w_out_eof_nxt   = 1'b1;
            w_frame_len_nxt = r_byte_cnt;
            w_err_short_nxt = (r_byte_cnt < L_MIN);
            w_err_align_nxt = r_phase;
            w_err_rx_nxt    = r_rx_err;
            w_crc_err_nxt   = w_crc_bad;
            w_close         = 1'b1;
          end else begin
            w_abort = 1'b1;
          end
        end else begin
          if (mii0_er) w_rx_err_nxt = 1'b1;
          w_phase_nxt = ~r_phase;
          if (!r_phase) begin
            w_lo_nxt = mii0_d;
          end else begin
            w_byte_cnt_nxt = r_byte_cnt + 1'b1;
            w_out_data_nxt = r_hold;
            w_out_sof_nxt  = r_sof_pend & r_hold_vld;
            if (r_hold_vld) w_sof_pend_nxt = 1'b0;
            if (r_byte_cnt == L_MAX) begin
              // Byte MAX+1 arrived: close on the held byte; CRC is meaningless for a truncated frame.
              w_state_nxt     = ST_DROP;
              w_hold_vld_nxt  = 1'b0;
              w_out_valid_nxt = 1'b1;
              w_out_eof_nxt   = 1'b1;
              w_frame_len_nxt = L_MAX;
              w_err_long_nxt  = 1'b1;
              w_err_rx_nxt    = r_rx_err | mii0_er;
              w_close         = 1'b1;
            end else begin
              w_out_valid_nxt = r_hold_vld;
              w_hold_nxt      = w_byte;
              w_hold_vld_nxt  = 1'b1;
            end
          end
        end
      end
      ST_DROP: begin
        if (!mii0_en) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_close_err = w_err_short_nxt | w_err_long_nxt | w_err_align_nxt | w_err_rx_nxt | w_crc_err_nxt;

    w_frame_cnt_nxt = r_frame_cnt;
    w_err_cnt_nxt   = r_err_cnt;
    if (w_close && !w_close_err && (r_frame_cnt != 16'hFFFF))
      w_frame_cnt_nxt = r_frame_cnt + 16'd1;
    if ((w_abort || (w_close && w_close_err)) && (r_err_cnt != 16'hFFFF))
      w_err_cnt_nxt = r_err_cnt + 16'd1;
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_sof   = r_out_sof;
  assign out_eof   = r_out_eof;
  assign frame_len = r_frame_len;
  assign err_short = r_err_short;
  assign err_long  = r_err_long;
  assign err_align = r_err_align;
  assign err_rx    = r_err_rx;
  assign crc_err   = r_crc_err;
  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_mii_rx_framer.sv
// Directed bench for mii_rx_framer: drives whole MII frames nibble by nibble and checks
// the captured beat stream, per-frame status and counters. Honours MII_RX_CRC_CHECK_EN.
module tb_mii_rx_framer;

  localparam int MIN_PRE = 3;

  logic        mii0_clk = 1'b0;
  logic        rst_n    = 1'b0;
  logic        mii0_en  = 1'b0;
  logic        mii0_er  = 1'b0;
  logic [3:0]  mii0_d   = 4'h0;
  logic [7:0]  out_data;
  logic        out_valid, out_sof, out_eof;
  logic [10:0] frame_len;
  logic        err_short, err_long, err_align, err_rx, crc_err;
  logic [15:0] frame_cnt, err_cnt;

  always #20 mii0_clk = ~mii0_clk;

  mii_rx_framer #(
    .MIN_FRAME_BYTES (64),
    .MAX_FRAME_BYTES (1522),
    .MIN_PRE_NIBBLES (MIN_PRE),
    .LEN_W           (11)
  ) dut (
    .mii0_clk  (mii0_clk),
    .rst_n     (rst_n),
    .mii0_en   (mii0_en),
    .mii0_er   (mii0_er),
    .mii0_d    (mii0_d),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .frame_len (frame_len),
    .err_short (err_short),
    .err_long  (err_long),
    .err_align (err_align),
    .err_rx    (err_rx),
    .crc_err   (crc_err),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_fc = 0;
  int exp_ec = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Beat capture, sampled on the falling edge away from output updates.
  logic [7:0]  cap_q[$];
  logic [7:0]  tx_q[$];
  int          cap_sof_n, cap_sof_idx, cap_eof_n, cap_eof_idx;
  logic [10:0] cap_len;
  logic [4:0]  cap_err;

  always @(negedge mii0_clk) begin
    if (out_valid) begin
      if (out_sof) begin
        cap_sof_n++;
        cap_sof_idx = cap_q.size();
      end
      if (out_eof) begin
        cap_eof_n++;
        cap_eof_idx = cap_q.size();
        cap_len     = frame_len;
        cap_err     = {err_short, err_long, err_align, err_rx, crc_err};
      end
      cap_q.push_back(out_data);
    end
  end

  task automatic clear_cap();
    cap_q.delete();
    cap_sof_n   = 0;
    cap_sof_idx = -1;
    cap_eof_n   = 0;
    cap_eof_idx = -1;
    cap_len     = '0;
    cap_err     = '0;
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Header + text, padded to total-4 bytes, then FCS; optional single-bit corruption.
  task automatic build_frame(input int total, input int flip_byte);
    logic [7:0]  hdr [14];
    string       txt;
    logic [31:0] crc;
    hdr = '{8'h54, 8'hff, 8'h01, 8'h21, 8'h23, 8'h24,
            8'h12, 8'h34, 8'h56, 8'h78, 8'h9a, 8'hbc, 8'h12, 8'h34};
    txt = "The quick brown fox jumps over";
    tx_q.delete();
    for (int i = 0; i < 14; i++) tx_q.push_back(hdr[i]);
    for (int i = 0; i < 30; i++) tx_q.push_back(txt[i]);
    while (tx_q.size() < total - 4) tx_q.push_back(8'(tx_q.size()));
    crc = 32'hFFFF_FFFF;
    foreach (tx_q[i]) crc = crc_upd(crc, tx_q[i]);
    crc = ~crc;
    for (int i = 0; i < 4; i++) tx_q.push_back(crc[8*i +: 8]);
    if (flip_byte >= 0) tx_q[flip_byte] = tx_q[flip_byte] ^ 8'h01;
  endtask

  task automatic send_nib(input logic en, input logic er, input logic [3:0] d);
    @(negedge mii0_clk);
    mii0_en = en;
    mii0_er = er;
    mii0_d  = d;
  endtask

  task automatic send_frame(input int npre, input int extra_nib, input int er_byte, input int rst_byte);
    for (int i = 0; i < npre; i++) send_nib(1'b1, 1'b0, 4'h5);
    send_nib(1'b1, 1'b0, 4'hD);
    foreach (tx_q[i]) begin
      if (i == rst_byte) begin
        clear_cap();
        rst_n = 1'b0;
      end
      send_nib(1'b1, (i == er_byte), tx_q[i][3:0]);
      send_nib(1'b1, (i == er_byte), tx_q[i][7:4]);
      if (i == rst_byte) rst_n = 1'b1;
    end
    if (extra_nib != 0) send_nib(1'b1, 1'b0, 4'hA);
    for (int i = 0; i < 12; i++) send_nib(1'b0, 1'b0, 4'h0);
  endtask

  task automatic expect_frame(input string tag, input int beats, input int len, input logic [4:0] errs);
    int nd;
    chk({tag, "_beats"}, cap_q.size(), beats);
    chk({tag, "_sof_n"}, cap_sof_n, (beats > 0) ? 1 : 0);
    chk({tag, "_eof_n"}, cap_eof_n, (beats > 0) ? 1 : 0);
    if (beats > 0) begin
      chk({tag, "_sof_idx"}, cap_sof_idx, 0);
      chk({tag, "_eof_idx"}, cap_eof_idx, beats - 1);
      chk({tag, "_len"}, cap_len, len);
      chk({tag, "_err"}, cap_err, errs);
      nd = 0;
      foreach (cap_q[i]) if (i >= tx_q.size() || cap_q[i] !== tx_q[i]) nd++;
      chk({tag, "_data"}, nd, 0);
    end
    chk({tag, "_frame_cnt"}, frame_cnt, exp_fc);
    chk({tag, "_err_cnt"}, err_cnt, exp_ec);
    $display("frame %s: beats=%0d len=%0d err(s,l,a,rx,crc)=%b frame_cnt=%0d err_cnt=%0d",
             tag, cap_q.size(), cap_len, cap_err, frame_cnt, err_cnt);
  endtask

  initial begin
    clear_cap();
    repeat (3) @(negedge mii0_clk);
    chk("rst_flags", {out_valid, out_sof, out_eof, err_short, err_long, err_align, err_rx, crc_err}, 0);
    chk("rst_data", out_data, 0);
    chk("rst_len", frame_len, 0);
    chk("rst_cnts", {frame_cnt, err_cnt}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge mii0_clk);

    // 48-byte runt with valid FCS
    build_frame(48, -1); clear_cap(); send_frame(14, 0, -1, -1);
    exp_ec = 1;
    chk("t1_sof_byte", cap_q.size() > 0 ? cap_q[0] : 8'h00, 8'h54);
    expect_frame("t1_short", 48, 48, 5'b10000);

    // minimum-size good frame
    build_frame(64, -1); clear_cap(); send_frame(14, 0, -1, -1);
    exp_fc = 1;
    expect_frame("t2_good64", 64, 64, 5'b00000);

    // one payload bit flipped after FCS computed
    build_frame(64, 20); clear_cap(); send_frame(14, 0, -1, -1);
`ifdef MII_RX_CRC_CHECK_EN
    exp_ec = 2;
    expect_frame("t2_crcbad", 64, 64, 5'b00001);
`else
    exp_fc = 2;
    expect_frame("t2_crcbad", 64, 64, 5'b00000);
`endif

    // 65 bytes plus a trailing odd nibble
    build_frame(65, -1); clear_cap(); send_frame(14, 1, -1, -1);
    exp_ec++;
    expect_frame("t3_align", 65, 65, 5'b00100);

    // oversize frame truncated at 1522
    build_frame(1600, -1); clear_cap(); send_frame(14, 0, -1, -1);
    exp_ec++;
    expect_frame("t4_long", 1522, 1522, 5'b01000);

    // RX_ER during byte 20
    build_frame(64, -1); clear_cap(); send_frame(14, 0, 20, -1);
    exp_ec++;
    expect_frame("t5_rxer", 64, 64, 5'b00010);

    // preamble one nibble short of MIN_PRE -> dropped
    build_frame(64, -1); clear_cap(); send_frame(MIN_PRE - 1, 0, -1, -1);
    exp_ec++;
    expect_frame("t5_pre_short", 0, 0, 5'b00000);

    // preamble exactly MIN_PRE -> accepted
    build_frame(64, -1); clear_cap(); send_frame(MIN_PRE, 0, -1, -1);
    exp_fc++;
    expect_frame("t5_pre_min", 64, 64, 5'b00000);

    // SFD followed immediately by en low
    tx_q.delete(); clear_cap(); send_frame(7, 0, -1, -1);
    exp_ec++;
    expect_frame("t5_zero", 0, 0, 5'b00000);

    // reset pulse mid-frame, released while en is still high
    build_frame(64, -1); clear_cap(); send_frame(14, 0, -1, 30);
    exp_fc = 0;
    exp_ec = 0;
    expect_frame("t6_rst_mid", 0, 0, 5'b00000);

    build_frame(64, -1); clear_cap(); send_frame(14, 0, -1, -1);
    exp_fc = 1;
    expect_frame("t6_after_rst", 64, 64, 5'b00000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
